// File: rtl/id_stage.sv
// RV32I decode stage: instruction decode, immediate generation, 32x32 register file,
// load-use hazard detection, EX-redirect flush handling, stall counter and sticky illegal flag.
module id_stage #(
   parameter bit          BYPASS_EN = 1'b1,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      pc_IF_ID,
   input  logic [31:0]      instr_IF_ID,
   input  logic             flush_EX,
   input  logic [1:0]       WBsel_EX,
   input  logic             regwen_EX,
   input  logic [4:0]       dest_EX,
   input  logic             wb_regwen,
   input  logic [4:0]       wb_dest,
   input  logic [31:0]      wb_data,
   output logic [31:0]      pc_ID,
   output logic [31:0]      rs1_ID,
   output logic [31:0]      rs2_ID,
   output logic [31:0]      imm_ID,
   output logic [31:0]      instr_ID,
   output logic [4:0]       src1_ID,
   output logic [4:0]       src2_ID,
   output logic [4:0]       dest_ID,
   output logic [1:0]       WBsel_ID,
   output logic [3:0]       alu_control_ID,
   output logic             MemRW_ID,
   output logic             regwen_ID,
   output logic             PCsel_ID,
   output logic             stall_IF,
   output logic             clear_ID_EX,
   output logic [CNT_W-1:0] stall_count,
   output logic             illegal_sticky
);

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpFence  = 7'b0001111;
   localparam logic [6:0] OpSystem = 7'b1110011;

   localparam logic [3:0] AluAdd   = 4'd0;
   localparam logic [3:0] AluSub   = 4'd1;
   localparam logic [3:0] AluPassB = 4'd10;

   logic [31:0]      regs_q [1:31];
   logic [CNT_W-1:0] stall_count_q;
   logic             illegal_q;
   logic [6:0]       opcode;
   logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j;
   logic             use1, use2, illegal, load_use;

   function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt,
                                          input logic is_reg);
      logic [3:0] fn;
      unique case (f3)
         3'b000:  fn = (is_reg && alt) ? AluSub : AluAdd;
         3'b001:  fn = 4'd2;
         3'b010:  fn = 4'd3;
         3'b011:  fn = 4'd4;
         3'b100:  fn = 4'd5;
         3'b101:  fn = alt ? 4'd7 : 4'd6;
         3'b110:  fn = 4'd8;
         default: fn = 4'd9;
      endcase
      return fn;
   endfunction

   assign pc_ID    = pc_IF_ID;
   assign instr_ID = instr_IF_ID;
   assign src1_ID  = instr_IF_ID[19:15];
   assign src2_ID  = instr_IF_ID[24:20];
   assign dest_ID  = instr_IF_ID[11:7];
   assign opcode   = instr_IF_ID[6:0];

   assign imm_i = {{20{instr_IF_ID[31]}}, instr_IF_ID[31:20]};
   assign imm_s = {{20{instr_IF_ID[31]}}, instr_IF_ID[31:25], instr_IF_ID[11:7]};
   assign imm_b = {{20{instr_IF_ID[31]}}, instr_IF_ID[7], instr_IF_ID[30:25],
                   instr_IF_ID[11:8], 1'b0};
   assign imm_u = {instr_IF_ID[31:12], 12'b0};
   assign imm_j = {{12{instr_IF_ID[31]}}, instr_IF_ID[19:12], instr_IF_ID[20],
                   instr_IF_ID[30:21], 1'b0};

   always_comb begin
      imm_ID         = '0;
      alu_control_ID = AluAdd;
      WBsel_ID       = 2'b01;
      MemRW_ID       = 1'b0;
      regwen_ID      = 1'b0;
      PCsel_ID       = 1'b0;
      use1           = 1'b1;
      use2           = 1'b0;
      illegal        = 1'b0;
      case (opcode)
         OpLui:    begin imm_ID = imm_u; regwen_ID = 1'b1; alu_control_ID = AluPassB;
                         use1 = 1'b0; end
         OpAuipc:  begin imm_ID = imm_u; regwen_ID = 1'b1; use1 = 1'b0; end
         OpJal:    begin imm_ID = imm_j; regwen_ID = 1'b1; WBsel_ID = 2'b10; PCsel_ID = 1'b1;
                         use1 = 1'b0; end
         OpJalr:   begin imm_ID = imm_i; regwen_ID = 1'b1; WBsel_ID = 2'b10; PCsel_ID = 1'b1; end
         OpBranch: begin imm_ID = imm_b; alu_control_ID = AluSub; PCsel_ID = 1'b1;
                         use2 = 1'b1; end
         OpLoad:   begin imm_ID = imm_i; regwen_ID = 1'b1; WBsel_ID = 2'b00; end
         OpStore:  begin imm_ID = imm_s; MemRW_ID = 1'b1; use2 = 1'b1; end
         OpImm:    begin imm_ID = imm_i; regwen_ID = 1'b1;
                         alu_control_ID = alu_fn(instr_IF_ID[14:12], instr_IF_ID[30], 1'b0); end
         OpReg:    begin regwen_ID = 1'b1; use2 = 1'b1;
                         alu_control_ID = alu_fn(instr_IF_ID[14:12], instr_IF_ID[30], 1'b1); end
         OpFence, OpSystem: imm_ID = imm_i;
         default:  begin use1 = 1'b0; illegal = 1'b1; end
      endcase
   end

   // Reads are forced to zero while reset is held, and x0 never comes from the array.
   always_comb begin
      rs1_ID = '0;
      if (rst && src1_ID != 5'd0) begin
         if (BYPASS_EN && wb_regwen && wb_dest == src1_ID) rs1_ID = wb_data;
         else                                              rs1_ID = regs_q[src1_ID];
      end
   end

   always_comb begin
      rs2_ID = '0;
      if (rst && src2_ID != 5'd0) begin
         if (BYPASS_EN && wb_regwen && wb_dest == src2_ID) rs2_ID = wb_data;
         else                                              rs2_ID = regs_q[src2_ID];
      end
   end

   assign load_use = (WBsel_EX == 2'b00) && regwen_EX && (dest_EX != 5'd0) &&
                     ((use1 && dest_EX == src1_ID) || (use2 && dest_EX == src2_ID));

   // A redirect squashes the decoding instruction, so it overrides any load-use stall.
   assign stall_IF    = load_use && !flush_EX;
   assign clear_ID_EX = load_use || flush_EX;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 1; i < 32; i++) regs_q[i] <= '0;
      end else if (wb_regwen && wb_dest != 5'd0) begin
         regs_q[wb_dest] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_count_q <= '0;
         illegal_q     <= 1'b0;
      end else begin
         if (stall_IF)                           stall_count_q <= stall_count_q + CNT_W'(1);
         if (illegal && !stall_IF && !flush_EX) illegal_q     <= 1'b1;
      end
   end

   assign stall_count    = stall_count_q;
   assign illegal_sticky = illegal_q;

endmodule
